// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Flush FSM states, default depth and stage index names.
package pipeline_hazard_ctrl_pkg;

    localparam int DEF_STAGES = 6;

    localparam int PC  = 0;
    localparam int IF  = 1;
    localparam int ID  = 2;
    localparam int EX  = 3;
    localparam int MEM = 4;
    localparam int WB  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Request/response bundle between the pipeline and the hazard controller.
// master drives the requests, slave (the controller) drives the controls.
import pipeline_hazard_ctrl_pkg::*;

interface pipeline_hazard_ctrl_if #(
    parameter int STAGES = DEF_STAGES,
    parameter int SW     = $clog2(STAGES)
);
    logic [STAGES-1:0] stall_req;
    logic              flush_req;
    logic [SW-1:0]     flush_stage;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] flush;
    logic              busy;
    logic              stall_timeout;
    logic [31:0]       stall_cycles;

    modport master (
        output stall_req, flush_req, flush_stage,
        input  stall, flush, busy,
        input  stall_timeout, stall_cycles
    );

    modport slave (
        input  stall_req, flush_req, flush_stage,
        output stall, flush, busy,
        output stall_timeout, stall_cycles
    );
endinterface

// File: rtl/stage_mask_gen.sv
// Thermometer mask: bits 0..idx set when en, otherwise all zero.
module stage_mask_gen #(
    parameter int N = 6,
    parameter int W = 3
) (
    input  logic [W-1:0] idx,
    input  logic         en,
    output logic [N-1:0] mask
);
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++)
            mask[i] = en && (i <= int'(idx));
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush controller with a deferred-flush FSM,
// stall-run watchdog and a free-running stall cycle counter.
import pipeline_hazard_ctrl_pkg::*;

module pipeline_hazard_ctrl #(
    parameter int STAGES        = DEF_STAGES,
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 255,
    parameter int SW            = $clog2(STAGES)
) (
    input  logic clk,
    input  logic rst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam logic [3:0]  FC = 4'(FLUSH_CYCLES);
    localparam logic [15:0] TO = 16'(STALL_TIMEOUT);
    localparam logic [SW-1:0] LAST = SW'(STAGES - 1);

    hz_state_t state, state_n;
    logic [SW-1:0] tgt, tgt_n, t_eff;
    logic [SW-1:0] hi_idx, fs_c;
    logic [3:0] cnt, cnt_n;
    logic [15:0] run, run_n;
    logic to_q;
    logic [31:0] cyc;
    logic any_stall, take, block;
    logic [STAGES-1:0] stall_raw, flush_raw, stall_v;

    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < STAGES; i++)
            if (hz.stall_req[i]) hi_idx = SW'(i);
    end

    assign any_stall = |hz.stall_req;
    assign fs_c = (int'(hz.flush_stage) >= STAGES)
                ? LAST : hz.flush_stage;

    // A request widens the target; a narrower one is dropped.
    assign take  = hz.flush_req
                && ((state == IDLE) || (fs_c >= tgt));
    assign t_eff = take ? fs_c : tgt;
    assign block = any_stall && (hi_idx > t_eff);

    stage_mask_gen #(.N(STAGES), .W(SW)) u_stall_mask (
        .idx  (hi_idx),
        .en   (any_stall),
        .mask (stall_raw)
    );

    stage_mask_gen #(.N(STAGES), .W(SW)) u_flush_mask (
        .idx  (tgt),
        .en   (state == FLUSH),
        .mask (flush_raw)
    );

    always_comb begin
        state_n = state;
        tgt_n   = t_eff;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (hz.flush_req) begin
                    state_n = block ? PEND : FLUSH;
                    cnt_n   = FC;
                end
            end
            PEND: begin
                if (!block) begin
                    state_n = FLUSH;
                    cnt_n   = FC;
                end
            end
            FLUSH: begin
                if (take) begin
                    cnt_n = FC;
                end else if (cnt <= 4'd1) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign stall_v = rst ? (stall_raw & ~flush_raw) : '0;

    always_comb begin
        run_n = '0;
        if (|stall_v)
            run_n = (run == TO) ? run : run + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            tgt   <= '0;
            cnt   <= '0;
            run   <= '0;
            to_q  <= 1'b0;
            cyc   <= '0;
        end else begin
            state <= state_n;
            tgt   <= tgt_n;
            cnt   <= cnt_n;
            run   <= run_n;
            to_q  <= to_q | (run_n == TO);
            if (|stall_v) cyc <= cyc + 32'd1;
        end
    end

    assign hz.stall         = stall_v;
    assign hz.flush         = rst ? flush_raw : '0;
    assign hz.busy          = (state != IDLE);
    assign hz.stall_timeout = to_q;
    assign hz.stall_cycles  = cyc;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and random stimulus against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;
    localparam int N  = 6;
    localparam int FC = 2;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    int   npass = 0;
    int   ntot  = 0;

    pipeline_hazard_ctrl_if #(.STAGES(N)) hz ();

    pipeline_hazard_ctrl #(
        .STAGES(N), .FLUSH_CYCLES(FC), .STALL_TIMEOUT(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    bit m_pend, m_fl, m_to;
    int m_t, m_left, m_run;
    logic [31:0] m_cyc;

    function automatic int hi_of(logic [N-1:0] v);
        int h = -1;
        for (int i = 0; i < N; i++) if (v[i]) h = i;
        return h;
    endfunction

    function automatic logic [N-1:0] thermo(int k);
        logic [N-1:0] m = '0;
        for (int i = 0; i < N; i++) if (i <= k) m[i] = 1'b1;
        return m;
    endfunction

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s obs=%0h exp=%0h t=%0t",
                    tag, obs, exp, $time);
    endtask

    task automatic step(bit r, logic [N-1:0] sr,
                        bit fr, logic [2:0] fs);
        int hi, fsc;
        logic [N-1:0] e_st, e_fl;
        rst = r;
        hz.stall_req = sr;
        hz.flush_req = fr;
        hz.flush_stage = fs;
        #1;
        hi = hi_of(sr);
        e_fl = m_fl ? thermo(m_t) : '0;
        e_st = thermo(hi) & ~e_fl;
        if (!r) begin
            e_fl = '0;
            e_st = '0;
        end
        chk("stall", 32'(hz.stall), 32'(e_st));
        chk("flush", 32'(hz.flush), 32'(e_fl));
        chk("busy", 32'(hz.busy), 32'(m_pend | m_fl));
        chk("timeout", 32'(hz.stall_timeout), 32'(m_to));
        chk("cycles", hz.stall_cycles, m_cyc);
        @(posedge clk);
        fsc = (int'(fs) > N - 1) ? N - 1 : int'(fs);
        if (!r) begin
            m_pend = 0; m_fl = 0; m_to = 0;
            m_t = 0; m_left = 0; m_run = 0; m_cyc = '0;
        end else begin
            if (e_st != '0) begin
                m_cyc++;
                m_run = (m_run + 1 > TO) ? TO : m_run + 1;
            end else begin
                m_run = 0;
            end
            if (m_run >= TO) m_to = 1;
            if (!m_pend && !m_fl) begin
                if (fr) begin
                    m_t = fsc;
                    if (hi > m_t) m_pend = 1;
                    else begin m_fl = 1; m_left = FC; end
                end
            end else if (m_pend) begin
                if (fr && fsc >= m_t) m_t = fsc;
                if (!(hi > m_t)) begin
                    m_pend = 0; m_fl = 1; m_left = FC;
                end
            end else begin
                if (fr && fsc >= m_t) begin
                    m_t = fsc; m_left = FC;
                end else begin
                    m_left--;
                    if (m_left == 0) m_fl = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        hz.stall_req = '0;
        hz.flush_req = 1'b0;
        hz.flush_stage = '0;
        m_pend = 0; m_fl = 0; m_to = 0;
        m_t = 0; m_left = 0; m_run = 0; m_cyc = '0;
        @(negedge clk);
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        chk("rst_busy", 32'(hz.busy), 32'd0);

        // three stall cycles at stage 2
        for (int i = 0; i < 3; i++) step(1, 6'b000100, 0, 0);
        step(1, '0, 0, 0);
        chk("st_cycles3", hz.stall_cycles, 32'd3);
        chk("st_to0", 32'(hz.stall_timeout), 32'd0);

        // plain flush of stage 3, two cycles
        step(1, '0, 1, 3'd3);
        chk("fl_first", 32'(hz.flush), 32'h0f);
        step(1, '0, 0, 0);
        chk("fl_second", 32'(hz.flush), 32'h0f);
        step(1, '0, 0, 0);
        chk("fl_done", 32'(hz.flush), 32'h00);
        step(1, '0, 0, 0);

        // deferred flush behind a stage-4 stall
        step(1, 6'b010000, 1, 3'd2);
        for (int i = 0; i < 4; i++) step(1, 6'b010000, 0, 0);
        step(1, '0, 0, 0);
        chk("pend_fl", 32'(hz.flush), 32'h07);
        step(1, '0, 0, 0);
        step(1, '0, 0, 0);

        // widen then ignore a narrower request
        step(1, '0, 1, 3'd2);
        step(1, '0, 1, 3'd4);
        chk("widen", 32'(hz.flush), 32'h1f);
        step(1, '0, 1, 3'd1);
        step(1, '0, 0, 0);
        step(1, '0, 0, 0);
        step(1, '0, 1, 3'd7);
        step(1, 6'b100000, 0, 0);
        step(1, 6'b100000, 0, 0);

        // watchdog
        step(0, '0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 6'b000001, 0, 0);
        for (int i = 0; i < 3; i++) step(1, '0, 0, 0);
        chk("to_sticky", 32'(hz.stall_timeout), 32'd1);

        // reset in the middle of a flush
        step(1, '0, 1, 3'd5);
        step(0, 6'b000011, 0, 0);
        chk("rst_fl", 32'(hz.flush), 32'd0);
        chk("rst_bz", 32'(hz.busy), 32'd0);
        chk("rst_cy", hz.stall_cycles, 32'd0);

        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] sr;
            sr = ($urandom_range(0, 2) == 0)
               ? N'($urandom) : '0;
            if ($urandom_range(0, 3) == 0)
                sr = N'(1 << $urandom_range(0, N - 1));
            step(($urandom_range(0, 79) != 0), sr,
                 ($urandom_range(0, 4) == 0),
                 3'($urandom));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
